// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - pipelined decode control with load-use hazard detection, forwarding and event counters
// Optional feature macro: CTRL_PIPE_FORWARD_EN (defined: EX-stage forwarding, load-use stall only;
// undefined: forwarding tied off, stall on any in-flight EX/MEM producer of a used source)
module ctrl_pipe #(
   parameter int OP_W   = 7,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [OP_W-1:0]   Op_i,
   input  logic [ADDR_W-1:0] RS1addr_i,
   input  logic [ADDR_W-1:0] RS2addr_i,
   input  logic [ADDR_W-1:0] RDaddr_i,
   input  logic              Flush_i,
   output logic [1:0]        ALUOp_o,
   output logic              ALUSrc_o,
   output logic              MemRead_o,
   output logic              MemWrite_o,
   output logic              RegWrite_o,
   output logic              MemtoReg_o,
   output logic [ADDR_W-1:0] WBrd_o,
   output logic              PCWrite_o,
   output logic              IFIDWrite_o,
   output logic              IFIDFlush_o,
   output logic [1:0]        ForwardA_o,
   output logic [1:0]        ForwardB_o,
   output logic [CNT_W-1:0]  StallCnt_o,
   output logic [CNT_W-1:0]  FlushCnt_o
);

   localparam logic [OP_W-1:0] OP_R      = OP_W'(7'b0110011);
   localparam logic [OP_W-1:0] OP_I      = OP_W'(7'b0010011);
   localparam logic [OP_W-1:0] OP_LOAD   = OP_W'(7'b0000011);
   localparam logic [OP_W-1:0] OP_STORE  = OP_W'(7'b0100011);
   localparam logic [OP_W-1:0] OP_BRANCH = OP_W'(7'b1100011);

   // ID-stage decode
   logic [1:0]        id_alu_op;
   logic              id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg;
   logic              id_rs1_used, id_rs2_used;
   logic [ADDR_W-1:0] id_rd;

   // ID/EX
   logic [1:0]        ex_alu_op;
   logic              ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
   logic [ADDR_W-1:0] ex_rd;
`ifdef CTRL_PIPE_FORWARD_EN
   logic [ADDR_W-1:0] ex_rs1, ex_rs2;
`endif

   // EX/MEM
   logic              mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg;
   logic [ADDR_W-1:0] mem_rd;

   // MEM/WB
   logic              wb_reg_write, wb_mem_to_reg;
   logic [ADDR_W-1:0] wb_rd;

   logic              ex_hit, mem_hit, hazard, stall;
   logic [CNT_W-1:0]  stall_cnt, flush_cnt;

   // Opcode to control bits; unrecognised opcodes become a full bubble
   always_comb begin
      id_alu_op     = 2'b00;
      id_alu_src    = 1'b0;
      id_mem_read   = 1'b0;
      id_mem_write  = 1'b0;
      id_reg_write  = 1'b0;
      id_mem_to_reg = 1'b0;
      id_rs1_used   = 1'b0;
      id_rs2_used   = 1'b0;
      id_rd         = RDaddr_i;
      case (Op_i)
         OP_R: begin
            id_reg_write = 1'b1;
            id_alu_op    = 2'b10;
            id_rs1_used  = 1'b1;
            id_rs2_used  = 1'b1;
         end
         OP_I: begin
            id_reg_write = 1'b1;
            id_alu_src   = 1'b1;
            id_rs1_used  = 1'b1;
         end
         OP_LOAD: begin
            id_mem_read   = 1'b1;
            id_mem_to_reg = 1'b1;
            id_reg_write  = 1'b1;
            id_alu_src    = 1'b1;
            id_rs1_used   = 1'b1;
         end
         OP_STORE: begin
            id_mem_write = 1'b1;
            id_alu_src   = 1'b1;
            id_rs1_used  = 1'b1;
            id_rs2_used  = 1'b1;
         end
         OP_BRANCH: begin
            id_alu_op   = 2'b01;
            id_rs1_used = 1'b1;
            id_rs2_used = 1'b1;
         end
         default: id_rd = '0;
      endcase
   end

   // Hazard detection; a taken branch in ID always wins over a stall
   always_comb begin
      ex_hit  = (ex_rd != '0) &&
                ((id_rs1_used && (ex_rd == RS1addr_i)) || (id_rs2_used && (ex_rd == RS2addr_i)));
      mem_hit = (mem_rd != '0) &&
                ((id_rs1_used && (mem_rd == RS1addr_i)) || (id_rs2_used && (mem_rd == RS2addr_i)));
`ifdef CTRL_PIPE_FORWARD_EN
      hazard  = ex_mem_read && ex_hit;
`else
      hazard  = (ex_reg_write && ex_hit) || (mem_reg_write && mem_hit);
`endif
      stall   = rst_i && !Flush_i && hazard;
   end

   // Front-end controls and forwarding selects, forced to safe values during reset
   always_comb begin
      PCWrite_o   = !stall;
      IFIDWrite_o = !stall;
      IFIDFlush_o = rst_i && Flush_i;
      ForwardA_o  = 2'b00;
      ForwardB_o  = 2'b00;
`ifdef CTRL_PIPE_FORWARD_EN
      if (rst_i) begin
         if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs1))
            ForwardA_o = 2'b10;
         else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs1))
            ForwardA_o = 2'b01;
         if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs2))
            ForwardB_o = 2'b10;
         else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs2))
            ForwardB_o = 2'b01;
      end
`endif
   end

   // Stage registers: ID/EX takes a bubble on stall, lower stages always advance
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         ex_alu_op      <= 2'b00;
         ex_alu_src     <= 1'b0;
         ex_mem_read    <= 1'b0;
         ex_mem_write   <= 1'b0;
         ex_reg_write   <= 1'b0;
         ex_mem_to_reg  <= 1'b0;
         ex_rd          <= '0;
`ifdef CTRL_PIPE_FORWARD_EN
         ex_rs1         <= '0;
         ex_rs2         <= '0;
`endif
         mem_mem_read   <= 1'b0;
         mem_mem_write  <= 1'b0;
         mem_reg_write  <= 1'b0;
         mem_mem_to_reg <= 1'b0;
         mem_rd         <= '0;
         wb_reg_write   <= 1'b0;
         wb_mem_to_reg  <= 1'b0;
         wb_rd          <= '0;
      end else begin
         if (stall) begin
            ex_alu_op     <= 2'b00;
            ex_alu_src    <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_rd         <= '0;
`ifdef CTRL_PIPE_FORWARD_EN
            ex_rs1        <= '0;
            ex_rs2        <= '0;
`endif
         end else begin
            ex_alu_op     <= id_alu_op;
            ex_alu_src    <= id_alu_src;
            ex_mem_read   <= id_mem_read;
            ex_mem_write  <= id_mem_write;
            ex_reg_write  <= id_reg_write;
            ex_mem_to_reg <= id_mem_to_reg;
            ex_rd         <= id_rd;
`ifdef CTRL_PIPE_FORWARD_EN
            ex_rs1        <= RS1addr_i;
            ex_rs2        <= RS2addr_i;
`endif
         end
         mem_mem_read   <= ex_mem_read;
         mem_mem_write  <= ex_mem_write;
         mem_reg_write  <= ex_reg_write;
         mem_mem_to_reg <= ex_mem_to_reg;
         mem_rd         <= ex_rd;
         wb_reg_write   <= mem_reg_write;
         wb_mem_to_reg  <= mem_mem_to_reg;
         wb_rd          <= mem_rd;
      end
   end

   // Saturating stall and flush event counters
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (Flush_i && (flush_cnt != '1))
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

   assign ALUOp_o    = ex_alu_op;
   assign ALUSrc_o   = ex_alu_src;
   assign MemRead_o  = mem_mem_read;
   assign MemWrite_o = mem_mem_write;
   assign RegWrite_o = wb_reg_write;
   assign MemtoReg_o = wb_mem_to_reg;
   assign WBrd_o     = wb_rd;
   assign StallCnt_o = stall_cnt;
   assign FlushCnt_o = flush_cnt;

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Pipelined successor to the single-cycle decode control unit for the 5-stage RV32 subset core.
- Decodes the ID-stage opcode into control bits and carries them through ID/EX, EX/MEM and MEM/WB registers together with rd/rs addresses.
- Detects load-use hazards, generates stall and flush controls, and counts stall/flush events.
- Sits between IF/ID and the datapath stage registers; the datapath consumes only stage-aligned control from this block.

Parameters:
- OP_W, 7, opcode width.
- ADDR_W, 5, register address width.
- CNT_W, 16, width of the saturating event counters.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; synchronous, active-low.
- Op_i  in  OP_W  opcode of the instruction in ID.
- RS1addr_i  in  ADDR_W  rs1 of the ID instruction.
- RS2addr_i  in  ADDR_W  rs2 of the ID instruction.
- RDaddr_i  in  ADDR_W  rd of the ID instruction.
- Flush_i  in  1  ID-stage branch taken; squashes the wrong-path instruction.
- ALUOp_o  out  2  EX-stage ALU op: 10 R, 01 branch, 00 other.
- ALUSrc_o  out  1  EX-stage operand B select: 1 imm, 0 reg.
- MemRead_o  out  1  MEM-stage load.
- MemWrite_o  out  1  MEM-stage store.
- RegWrite_o  out  1  WB-stage register write.
- MemtoReg_o  out  1  WB-stage select: 1 mem, 0 ALU.
- WBrd_o  out  ADDR_W  WB-stage destination register.
- PCWrite_o  out  1  PC update enable.
- IFIDWrite_o  out  1  IF/ID load enable.
- IFIDFlush_o  out  1  IF/ID clear.
- ForwardA_o  out  2  EX operand A forward select.
- ForwardB_o  out  2  EX operand B forward select.
- StallCnt_o  out  CNT_W  saturating stall-cycle count.
- FlushCnt_o  out  CNT_W  saturating flush count.

Behaviour:
- Opcode decode:
  - R 0110011: RegWrite, ALUOp 10.
  - I 0010011: RegWrite, ALUSrc.
  - LOAD 0000011: MemRead, MemtoReg, RegWrite, ALUSrc.
  - STORE 0100011: MemWrite, ALUSrc.
  - BRANCH 1100011: ALUOp 01.
  - Any other opcode decodes to a bubble: all control bits 0.
- rs1 is "used" for R, I, LOAD, STORE, BRANCH. rs2 is "used" for R, STORE, BRANCH.
- Reset (rst_i=0 at edge):
  - All stage registers, rd/rs fields and counters go to 0.
  - While rst_i=0 the combinational outputs are forced: Stall=0, PCWrite_o=1, IFIDWrite_o=1, IFIDFlush_o=0, Forward=00.
- Hazard: stall = EX.MemRead & EX.rd!=0 & ((rs1 used & EX.rd==rs1) | (rs2 used & EX.rd==rs2)).
- Stall effects:
  - PCWrite_o=0, IFIDWrite_o=0.
  - ID/EX loads a bubble (control 0, rd 0).
  - EX/MEM and MEM/WB advance normally.
  - A stall lasts exactly 1 cycle for a load-use pair.
- Flush effects:
  - Flush_i=1: IFIDFlush_o=1, PCWrite_o=1, IFIDWrite_o=1.
  - Stall is suppressed; flush has priority over stall.
  - ID/EX loads the branch's own decode; branch control is not squashed.
- Pipeline advance: EX/MEM <= ID/EX and MEM/WB <= EX/MEM every cycle; there is no back-pressure below ID.
- Control latency from ID decode:
  - ALUOp/ALUSrc valid 1 cycle after ID.
  - MemRead/MemWrite valid 2 cycles after ID.
  - RegWrite/MemtoReg/WBrd valid 3 cycles after ID.
- Forwarding (see Optional Feature):
  - ForwardA = 10 if MEM.RegWrite & MEM.rd!=0 & MEM.rd==EX.rs1.
  - Else ForwardA = 01 if WB.RegWrite & WB.rd!=0 & WB.rd==EX.rs1.
  - Else ForwardA = 00.
  - ForwardB is identical using EX.rs2.
  - The MEM-stage source has priority over WB.
- Counters:
  - StallCnt +1 per cycle with stall asserted.
  - FlushCnt +1 per cycle with Flush_i=1.
  - Both saturate at 2^CNT_W-1 and never wrap.

Optional Feature:
- Macro: CTRL_PIPE_FORWARD_EN.
- Defined: forwarding logic as above; stall on load-use only.
- Undefined:
  - ForwardA_o and ForwardB_o are tied to 00.
  - Stall additionally asserts on any used-source match with EX.rd or MEM.rd where that stage has RegWrite=1 and rd!=0.
  - Register file write-before-read covers the WB stage.

Test Plan:
- Reset: hold rst_i=0 for 2 cycles with Op_i=0110011. All stage outputs 0, counters 0, PCWrite_o=1; first R-type RegWrite_o=1 appears 3 cycles after release.
- Load-use: LOAD rd=5, then R rs1=5 rs2=6. Exactly 1 cycle with PCWrite_o=0, IFIDWrite_o=0, StallCnt=1; bubble seen as MemRead_o=0 in MEM; with FORWARD_EN, ForwardA_o=01 when the R-type reaches EX.
- x0 guard: LOAD rd=0, then R rs1=0. No stall, Forward=00.
- Flush vs stall: LOAD rd=3, then BRANCH rs1=3 with Flush_i=1 same cycle. IFIDFlush_o=1, PCWrite_o=1, no stall, FlushCnt=1.
- Forward priority (FORWARD_EN): I rd=7; I rd=7; R rs1=7 rs2=7. ForwardA_o=ForwardB_o=10, not 01.
- Saturation: CNT_W=2, 5 consecutive load-use pairs. StallCnt_o holds 3.
